// File: rtl/chebyshev_coeff_sequencer_if.sv
// Bundle of the sample intake, coefficient write port and beat output stream
// of chebyshev_coeff_sequencer. The sequencer connects to the slave modport.
interface chebyshev_coeff_sequencer_if #(
    parameter int WL = 8,
    parameter int CL = 8,
    parameter int AW = 2
);
    logic signed [WL-1:0] x_in;
    logic                 x_valid;
    logic                 x_ready;
    logic                 coeff_wr_en;
    logic [AW-1:0]        coeff_wr_addr;
    logic signed [CL-1:0] coeff_wr_data;
    logic                 coeff_wr_err;
    logic signed [WL-1:0] data_out;
    logic signed [CL-1:0] coeff_out;
    logic                 out_valid;
    logic                 out_ready;
    logic                 first_out;
    logic                 last_out;

    modport slave (
        input  x_in, x_valid, coeff_wr_en, coeff_wr_addr, coeff_wr_data, out_ready,
        output x_ready, coeff_wr_err, data_out, coeff_out, out_valid, first_out, last_out
    );

    modport master (
        output x_in, x_valid, coeff_wr_en, coeff_wr_addr, coeff_wr_data, out_ready,
        input  x_ready, coeff_wr_err, data_out, coeff_out, out_valid, first_out, last_out
    );
endinterface

// File: rtl/chebyshev_coeff_sequencer.sv
// Streams ORDER (x, c_k) beats per accepted sample from a programmable
// coefficient bank, with first/last markers and full downstream stall support.
module chebyshev_coeff_sequencer #(
    parameter int WL    = 8,
    parameter int CL    = 8,
    parameter int ORDER = 4,
    parameter int AW    = 2
) (
    input  logic                          clock,
    input  logic                          resetn,
    chebyshev_coeff_sequencer_if.slave    bus
);
    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t                   state_reg, state_next;
    logic [AW-1:0]            idx_reg, idx_next, idx_plus;
    logic                     x_ready_reg, x_ready_next;
    logic                     out_valid_reg, out_valid_next;
    logic signed [WL-1:0]     data_reg, data_next;
    logic signed [CL-1:0]     coeff_reg, coeff_next;
    logic                     first_reg, first_next;
    logic                     last_reg, last_next;
    logic                     err_reg, err_next;

    logic [ORDER-1:0][CL-1:0] coeff_bank;
    logic [ORDER-1:0]         bank_we;
    logic                     accept, beat_done, frame_end, wr_ok;

    assign accept    = (state_reg == IDLE) && bus.x_valid && x_ready_reg;
    assign beat_done = (state_reg == ISSUE) && out_valid_reg && bus.out_ready;
    assign frame_end = beat_done && (32'(idx_reg) == ORDER - 1);
    assign idx_plus  = idx_reg + AW'(1);
    // Writes land only while no frame is using the bank, including the accept edge.
    assign wr_ok     = bus.coeff_wr_en && (state_reg == IDLE) && !accept
                       && (32'(bus.coeff_wr_addr) < ORDER);

    for (genvar gi = 0; gi < ORDER; gi++) begin : g_bank
        logic signed [CL-1:0] c_reg;

        assign bank_we[gi] = wr_ok && (32'(bus.coeff_wr_addr) == gi);

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                c_reg <= '0;
            end else if (bank_we[gi]) begin
                c_reg <= bus.coeff_wr_data;
            end
        end

        assign coeff_bank[gi] = c_reg;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            x_ready_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            data_reg      <= '0;
            coeff_reg     <= '0;
            first_reg     <= 1'b0;
            last_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            x_ready_reg   <= x_ready_next;
            out_valid_reg <= out_valid_next;
            data_reg      <= data_next;
            coeff_reg     <= coeff_next;
            first_reg     <= first_next;
            last_reg      <= last_next;
            err_reg       <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)    state_next = ISSUE;
            ISSUE:   if (frame_end) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Every output is registered; this block computes what each register loads.
    always_comb begin
        idx_next       = idx_reg;
        x_ready_next   = x_ready_reg;
        out_valid_next = out_valid_reg;
        data_next      = data_reg;
        coeff_next     = coeff_reg;
        first_next     = first_reg;
        last_next      = last_reg;
        err_next       = bus.coeff_wr_en && !wr_ok;
        case (state_reg)
            IDLE: begin
                x_ready_next   = 1'b1;
                out_valid_next = 1'b0;
                if (accept) begin
                    x_ready_next   = 1'b0;
                    out_valid_next = 1'b1;
                    data_next      = bus.x_in;
                    coeff_next     = coeff_bank[0];
                    first_next     = 1'b1;
                    last_next      = (ORDER == 1);
                    idx_next       = '0;
                end
            end
            ISSUE: begin
                if (frame_end) begin
                    out_valid_next = 1'b0;
                    first_next     = 1'b0;
                    last_next      = 1'b0;
                    x_ready_next   = 1'b1;
                end else if (beat_done) begin
                    idx_next   = idx_plus;
                    coeff_next = coeff_bank[idx_plus];
                    first_next = 1'b0;
                    last_next  = (32'(idx_plus) == ORDER - 1);
                end
            end
            default: ;
        endcase
    end

    assign bus.x_ready      = x_ready_reg;
    assign bus.out_valid    = out_valid_reg;
    assign bus.data_out     = data_reg;
    assign bus.coeff_out    = coeff_reg;
    assign bus.first_out    = first_reg;
    assign bus.last_out     = last_reg;
    assign bus.coeff_wr_err = err_reg;
endmodule

// File: tb/tb_chebyshev_coeff_sequencer.sv
// Scoreboard bench: stimulus pushes expected beats, per-DUT monitors pop and
// compare on every transfer; an ORDER=3 instance covers the out-of-range write.
module tb_chebyshev_coeff_sequencer;
    localparam int WL = 8;
    localparam int CL = 8;
    localparam int AW = 2;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    chebyshev_coeff_sequencer_if #(.WL(WL), .CL(CL), .AW(AW)) bus4 ();
    chebyshev_coeff_sequencer_if #(.WL(WL), .CL(CL), .AW(AW)) bus3 ();

    chebyshev_coeff_sequencer #(.WL(WL), .CL(CL), .ORDER(4), .AW(AW)) dut4 (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus4.slave)
    );

    chebyshev_coeff_sequencer #(.WL(WL), .CL(CL), .ORDER(3), .AW(AW)) dut3 (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus3.slave)
    );

    typedef struct packed {
        logic signed [WL-1:0] d;
        logic signed [CL-1:0] c;
        logic                 f;
        logic                 l;
    } beat_t;

    beat_t exp4_q[$];
    beat_t exp3_q[$];
    int    checks = 0;
    int    errors = 0;
    int    xfers4 = 0;
    int    xfers3 = 0;
    logic signed [CL-1:0] model4 [4];
    logic signed [CL-1:0] model3 [3];
    bit    rdy_pat [7] = '{1, 0, 0, 1, 0, 1, 1};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp_beat(input string tag, input beat_t act, input beat_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got data=%0d coeff=%0d first=%0b last=%0b, expected data=%0d coeff=%0d first=%0b last=%0b",
                     tag, act.d, act.c, act.f, act.l, exp.d, exp.c, exp.f, exp.l);
        end else begin
            $display("%s: data=%0d coeff=%0d first=%0b last=%0b ok", tag, act.d, act.c, act.f, act.l);
        end
    endtask

    // Monitors sample on the falling edge, half a cycle before the transfer edge.
    beat_t prev4, prev3;
    bit    stall4 = 1'b0, stall3 = 1'b0;

    always @(negedge clock) begin
        beat_t cur;
        cur = '{bus4.data_out, bus4.coeff_out, bus4.first_out, bus4.last_out};
        if (stall4 && resetn) begin
            checks++;
            if (!bus4.out_valid || cur !== prev4) begin
                errors++;
                $display("FAIL stall_hold4: got valid=%0b data=%0d coeff=%0d, expected valid=1 data=%0d coeff=%0d",
                         bus4.out_valid, cur.d, cur.c, prev4.d, prev4.c);
            end
        end
        stall4 = resetn && bus4.out_valid && !bus4.out_ready;
        prev4  = cur;
        if (resetn && bus4.out_valid && bus4.out_ready) begin
            xfers4++;
            if (exp4_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat4: got data=%0d coeff=%0d, expected no beat", cur.d, cur.c);
            end else begin
                cmp_beat("beat4", cur, exp4_q.pop_front());
            end
        end
    end

    always @(negedge clock) begin
        beat_t cur;
        cur = '{bus3.data_out, bus3.coeff_out, bus3.first_out, bus3.last_out};
        if (stall3 && resetn) begin
            checks++;
            if (!bus3.out_valid || cur !== prev3) begin
                errors++;
                $display("FAIL stall_hold3: got data=%0d coeff=%0d, expected data=%0d coeff=%0d",
                         cur.d, cur.c, prev3.d, prev3.c);
            end
        end
        stall3 = resetn && bus3.out_valid && !bus3.out_ready;
        prev3  = cur;
        if (resetn && bus3.out_valid && bus3.out_ready) begin
            xfers3++;
            if (exp3_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat3: got data=%0d coeff=%0d, expected no beat", cur.d, cur.c);
            end else begin
                cmp_beat("beat3", cur, exp3_q.pop_front());
            end
        end
    end

    task automatic push_frame4(input logic signed [WL-1:0] x);
        for (int k = 0; k < 4; k++) exp4_q.push_back('{x, model4[k], k == 0, k == 3});
    endtask

    task automatic write4(input logic [AW-1:0] a, input logic signed [CL-1:0] d, input logic exp_err);
        bus4.coeff_wr_en   = 1'b1;
        bus4.coeff_wr_addr = a;
        bus4.coeff_wr_data = d;
        tick();
        bus4.coeff_wr_en = 1'b0;
        check("wr_err4", 32'(bus4.coeff_wr_err), 32'(exp_err));
        if (!exp_err) model4[a] = d;
        tick();
        check("wr_err_clear4", 32'(bus4.coeff_wr_err), 0);
    endtask

    task automatic write3(input logic [AW-1:0] a, input logic signed [CL-1:0] d, input logic exp_err);
        bus3.coeff_wr_en   = 1'b1;
        bus3.coeff_wr_addr = a;
        bus3.coeff_wr_data = d;
        tick();
        bus3.coeff_wr_en = 1'b0;
        check("wr_err3", 32'(bus3.coeff_wr_err), 32'(exp_err));
        if (!exp_err) model3[a] = d;
        tick();
        check("wr_err_clear3", 32'(bus3.coeff_wr_err), 0);
    endtask

    task automatic handshake4(input logic signed [WL-1:0] x);
        int n = 0;
        bus4.x_in    = x;
        bus4.x_valid = 1'b1;
        while (!bus4.x_ready && n < 50) begin
            tick();
            n++;
        end
        check("x_ready_wait4", 32'(n < 50), 1);
        tick();
        bus4.x_valid = 1'b0;
        check("first_beat_valid4", 32'(bus4.out_valid), 1);
        check("first_beat_first4", 32'(bus4.first_out), 1);
    endtask

    task automatic drain4(input string name);
        int n = 0;
        while (exp4_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check({"drain_", name}, 32'(exp4_q.size()), 0);
        check({"x_ready_return_", name}, 32'(bus4.x_ready), 1);
        check({"valid_low_", name}, 32'(bus4.out_valid), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected completion within 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int xb;
        int n;
        bus4.x_in = '0; bus4.x_valid = 1'b0; bus4.coeff_wr_en = 1'b0;
        bus4.coeff_wr_addr = '0; bus4.coeff_wr_data = '0; bus4.out_ready = 1'b1;
        bus3.x_in = '0; bus3.x_valid = 1'b0; bus3.coeff_wr_en = 1'b0;
        bus3.coeff_wr_addr = '0; bus3.coeff_wr_data = '0; bus3.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) model4[k] = '0;
        for (int k = 0; k < 3; k++) model3[k] = '0;

        repeat (2) @(posedge clock);
        #1;
        check("rst_x_ready", 32'(bus4.x_ready), 0);
        check("rst_out_valid", 32'(bus4.out_valid), 0);
        check("rst_data_out", 32'(bus4.data_out), 0);
        check("rst_coeff_out", 32'(bus4.coeff_out), 0);
        check("rst_first_last", {30'd0, bus4.first_out, bus4.last_out}, 0);
        check("rst_wr_err", 32'(bus4.coeff_wr_err), 0);
        resetn = 1'b1;
        #1;
        check("x_ready_before_edge", 32'(bus4.x_ready), 0);
        tick();
        check("x_ready_after_release", 32'(bus4.x_ready), 1);

        // Scenario 1: program bank, one unstalled frame.
        write4(2'd0, 8'sd15, 1'b0);
        write4(2'd1, 8'sd1, 1'b0);
        write4(2'd2, 8'sd0, 1'b0);
        write4(2'd3, -8'sd2, 1'b0);
        xb = xfers4;
        push_frame4(8'sd43);
        handshake4(8'sd43);
        drain4("t1");
        check("t1_xfers", 32'(xfers4 - xb), 4);

        // Scenario 2: same frame under the stall pattern.
        xb = xfers4;
        push_frame4(8'sd43);
        handshake4(8'sd43);
        for (int i = 0; i < 7; i++) begin
            bus4.out_ready = rdy_pat[i];
            tick();
        end
        bus4.out_ready = 1'b1;
        drain4("t2");
        check("t2_xfers", 32'(xfers4 - xb), 4);

        // Scenario 3: write during ISSUE is rejected; current and next frame keep c1=1.
        push_frame4(8'sd2);
        handshake4(8'sd2);
        write4(2'd1, 8'sd7, 1'b1);
        drain4("t3a");
        push_frame4(8'sd2);
        handshake4(8'sd2);
        drain4("t3b");

        // Write on the same edge as a sample handshake is rejected too.
        push_frame4(8'sd5);
        bus4.x_in = 8'sd5; bus4.x_valid = 1'b1;
        bus4.coeff_wr_en = 1'b1; bus4.coeff_wr_addr = 2'd2; bus4.coeff_wr_data = 8'sd99;
        tick();
        bus4.x_valid = 1'b0; bus4.coeff_wr_en = 1'b0;
        check("wr_err_on_accept", 32'(bus4.coeff_wr_err), 1);
        drain4("t3c");

        // Scenario 4: back-to-back samples with x_valid held high.
        xb = xfers4;
        push_frame4(8'sd2);
        push_frame4(8'sd1);
        bus4.x_in = 8'sd2; bus4.x_valid = 1'b1;
        n = 0;
        while (!bus4.x_ready && n < 50) begin tick(); n++; end
        tick();
        bus4.x_in = 8'sd1;
        n = 0;
        while (exp4_q.size() > 4 && n < 50) begin tick(); n++; end
        check("t4_gap_valid", 32'(bus4.out_valid), 0);
        check("t4_gap_x_ready", 32'(bus4.x_ready), 1);
        tick();
        bus4.x_valid = 1'b0;
        check("t4_second_valid", 32'(bus4.out_valid), 1);
        check("t4_second_data", 32'(bus4.data_out), 1);
        drain4("t4");
        check("t4_xfers", 32'(xfers4 - xb), 8);

        // Scenario 5: asynchronous reset while beat k=2 is presented.
        push_frame4(8'sd9);
        handshake4(8'sd9);
        tick();
        tick();
        check("t5_beat2_coeff", 32'(bus4.coeff_out), 32'(model4[2]));
        resetn = 1'b0;
        #1;
        check("t5_rst_valid", 32'(bus4.out_valid), 0);
        check("t5_rst_x_ready", 32'(bus4.x_ready), 0);
        check("t5_rst_first_last", {30'd0, bus4.first_out, bus4.last_out}, 0);
        check("t5_rst_coeff", 32'(bus4.coeff_out), 0);
        exp4_q.delete();
        for (int k = 0; k < 4; k++) model4[k] = '0;
        for (int k = 0; k < 3; k++) model3[k] = '0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
        xb = xfers4;
        push_frame4(8'sd1);
        handshake4(8'sd1);
        drain4("t5");
        check("t5_xfers", 32'(xfers4 - xb), 4);

        // Scenario 6: ORDER=3 instance rejects address 3 and keeps its bank.
        write3(2'd0, 8'sd5, 1'b0);
        write3(2'd1, 8'sd6, 1'b0);
        write3(2'd2, 8'sd7, 1'b0);
        write3(2'd3, 8'sd9, 1'b1);
        xb = xfers3;
        for (int k = 0; k < 3; k++) exp3_q.push_back('{-8'sd3, model3[k], k == 0, k == 2});
        bus3.x_in = -8'sd3; bus3.x_valid = 1'b1;
        n = 0;
        while (!bus3.x_ready && n < 50) begin tick(); n++; end
        tick();
        bus3.x_valid = 1'b0;
        n = 0;
        while (exp3_q.size() != 0 && n < 50) begin tick(); n++; end
        check("t6_drain", 32'(exp3_q.size()), 0);
        check("t6_xfers", 32'(xfers3 - xb), 3);
        check("t6_x_ready_return", 32'(bus3.x_ready), 1);

        tick();
        check("end_queue4", 32'(exp4_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
